// File: rtl/board_reset_status_if.sv
// Board reset/status bundle between the FPGA top wrapper and the reset sequencer.
//   pll_locked      : PLL lock, asynchronous to clk
//   status_in       : per-channel status levels, synchronous to clk
//   core_reset(_n)  : registered core reset and its registered inverse
//   led_out         : stretched status indicators
//   heartbeat       : blinks while the sequencer is in RUN
//   lock_lost_count : saturating RUN->LOCK_LOST event count
//   seq_state       : 0 WAIT_LOCK, 1 STABLE, 2 RUN, 3 LOCK_LOST
// slave modport is the sequencer side; master is the board/wrapper side.
interface board_reset_status_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
);
  logic             pll_locked;
  logic [N_CH-1:0]  status_in;
  logic             core_reset;
  logic             core_reset_n;
  logic [N_CH-1:0]  led_out;
  logic             heartbeat;
  logic [CNT_W-1:0] lock_lost_count;
  logic [1:0]       seq_state;

  modport slave (
    input  pll_locked, status_in,
    output core_reset, core_reset_n, led_out, heartbeat, lock_lost_count, seq_state
  );

  modport master (
    output pll_locked, status_in,
    input  core_reset, core_reset_n, led_out, heartbeat, lock_lost_count, seq_state
  );
endinterface

// File: rtl/board_reset_status_ctrl.sv
// Board-level reset sequencer and status-indicator block.
//   clk   : system clock (PLL output)
//   reset : asynchronous, active-high
//   bus   : board_reset_status_if.slave (pll_locked/status_in in; core_reset,
//           core_reset_n, led_out, heartbeat, lock_lost_count, seq_state out)
// Synchronises pll_locked, holds the core in reset until lock has been stable
// for LOCK_STABLE_CYCLES, re-asserts it for MIN_RESET_CYCLES on lock loss,
// stretches each status rising edge into an LED pulse and blinks a heartbeat
// while running.

// One retriggerable LED pulse stretcher.
//   clr    : force counter/LED low while still tracking the level
//   status : status level, synchronous to clk
//   led    : registered (hold != 0)
module board_reset_status_led_lane #(
  parameter int HOLD = 5,
  parameter int HW   = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic status,
  output logic led
);
  logic          prev;
  logic [HW-1:0] hold, hold_nxt;

  always_comb begin
    hold_nxt = hold;
    if (clr)                  hold_nxt = '0;
    else if (status && !prev) hold_nxt = HW'(HOLD);   // reload, no accumulation
    else if (hold != '0)      hold_nxt = hold - HW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= 1'b0;
      hold <= '0;
      led  <= 1'b0;
    end else begin
      // prev tracks the level even under clr, so a level already high at
      // release is not seen as an edge.
      prev <= status;
      hold <= hold_nxt;
      led  <= (hold_nxt != '0);
    end
  end
endmodule

module board_reset_status_ctrl #(
  parameter int N_CH               = 4,
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MIN_RESET_CYCLES   = 16,
  parameter int LED_HOLD_CYCLES    = 2**20,
  parameter int HEARTBEAT_DIV      = 2**24,
  parameter int CNT_W              = 8
) (
  input logic           clk,
  input logic           reset,
  board_reset_status_if.slave bus
);
  localparam int SW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int RW = (MIN_RESET_CYCLES > 1)   ? $clog2(MIN_RESET_CYCLES)   : 1;
  localparam int BW = (HEARTBEAT_DIV > 1)      ? $clog2(HEARTBEAT_DIV)      : 1;
  localparam int HW = $clog2(LED_HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2,
    LOCK_LOST = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic             lock_s;
  logic [SW-1:0]    stab_cnt, stab_nxt;
  logic [RW-1:0]    lost_cnt, lost_nxt;
  logic [BW-1:0]    hb_cnt;
  logic             heartbeat;
  logic             core_reset, core_reset_n;
  logic [CNT_W-1:0] lock_lost_count;
  logic [N_CH-1:0]  led;

  assign lock_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], bus.pll_locked};
  end

  always_comb begin
    state_nxt = state;
    stab_nxt  = stab_cnt;
    lost_nxt  = lost_cnt;
    case (state)
      WAIT_LOCK: if (lock_s) begin
        state_nxt = STABLE;
        stab_nxt  = '0;
      end
      STABLE: begin
        // Any drop discards the whole count.
        if (!lock_s)                                  state_nxt = WAIT_LOCK;
        else if (stab_cnt == SW'(LOCK_STABLE_CYCLES-1)) state_nxt = RUN;
        else                                          stab_nxt  = stab_cnt + SW'(1);
      end
      RUN: if (!lock_s) begin
        state_nxt = LOCK_LOST;
        lost_nxt  = '0;
      end
      LOCK_LOST: begin
        if (lost_cnt == RW'(MIN_RESET_CYCLES-1)) state_nxt = WAIT_LOCK;
        else                                     lost_nxt  = lost_cnt + RW'(1);
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= WAIT_LOCK;
      stab_cnt        <= '0;
      lost_cnt        <= '0;
      core_reset      <= 1'b1;
      core_reset_n    <= 1'b0;
      lock_lost_count <= '0;
      hb_cnt          <= '0;
      heartbeat       <= 1'b0;
    end else begin
      state    <= state_nxt;
      stab_cnt <= stab_nxt;
      lost_cnt <= lost_nxt;
      // Registered from next-state so reset edges line up with state changes.
      core_reset   <= (state_nxt != RUN);
      core_reset_n <= (state_nxt == RUN);
      if (state == RUN && !lock_s && lock_lost_count != '1)
        lock_lost_count <= lock_lost_count + CNT_W'(1);
      // Heartbeat counts only cycles spent in RUN; it is low outside RUN.
      if (state_nxt != RUN) begin
        hb_cnt    <= '0;
        heartbeat <= 1'b0;
      end else if (state == RUN) begin
        if (hb_cnt == BW'(HEARTBEAT_DIV-1)) begin
          hb_cnt    <= '0;
          heartbeat <= ~heartbeat;
        end else begin
          hb_cnt <= hb_cnt + BW'(1);
        end
      end
    end
  end

  board_reset_status_led_lane #(.HOLD(LED_HOLD_CYCLES), .HW(HW)) u_lane [N_CH-1:0] (
    .clk    (clk),
    .reset  (reset),
    .clr    (core_reset),
    .status (bus.status_in),
    .led    (led)
  );

  assign bus.core_reset      = core_reset;
  assign bus.core_reset_n    = core_reset_n;
  assign bus.led_out         = led;
  assign bus.heartbeat       = heartbeat;
  assign bus.lock_lost_count = lock_lost_count;
  assign bus.seq_state       = state;
endmodule

// File: tb/tb_board_reset_status_ctrl.sv
module tb_board_reset_status_ctrl;
  localparam int N_CH = 4;
  localparam int CNT_W = 8;
  localparam int LSC = 8;
  localparam int MRC = 4;
  localparam int LHC = 5;
  localparam int HBD = 3;
  localparam int NEVER = -1000000;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  board_reset_status_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  board_reset_status_ctrl #(
    .N_CH(N_CH), .SYNC_STAGES(2), .LOCK_STABLE_CYCLES(LSC), .MIN_RESET_CYCLES(MRC),
    .LED_HOLD_CYCLES(LHC), .HEARTBEAT_DIV(HBD), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Phases: 0 waiting for lock, 1 counting stable lock, 2 running, 3 lost.
  // LEDs are modelled by the time of the last accepted rising edge and the
  // heartbeat by the time RUN was entered.
  int  n = 0;
  int  m_ph = 0, m_stable = 0, m_lost = 0, m_llc = 0, m_run0 = 0;
  bit  m_p1 = 0, m_p2 = 0;
  bit  [N_CH-1:0] m_prev = '0;
  int  m_last [N_CH];

  always @(posedge clk) begin
    bit ls, cr_old;
    n++;
    if (reset) begin
      m_ph = 0; m_stable = 0; m_lost = 0; m_llc = 0;
      m_p1 = 0; m_p2 = 0; m_prev = '0;
      for (int i = 0; i < N_CH; i++) m_last[i] = NEVER;
    end else begin
      ls     = m_p2;               // pll_locked as seen two edges ago
      cr_old = (m_ph != 2);
      for (int i = 0; i < N_CH; i++) begin
        if (cr_old) m_last[i] = NEVER;
        else if (bus.status_in[i] && !m_prev[i]) m_last[i] = n;
      end
      m_prev = bus.status_in;
      case (m_ph)
        0: if (ls) begin m_ph = 1; m_stable = 0; end
        1: if (!ls) m_ph = 0;
           else if (m_stable == LSC-1) begin m_ph = 2; m_run0 = n; end
           else m_stable++;
        2: if (!ls) begin
             m_ph = 3; m_lost = 1;
             if (m_llc < 255) m_llc++;
           end
        default: if (m_lost == MRC) m_ph = 0; else m_lost++;
      endcase
      m_p2 = m_p1;
      m_p1 = bus.pll_locked;
    end
  end

  // Per-cycle compare, clear of the active edge.
  always @(posedge clk) begin
    bit [N_CH-1:0] led_exp;
    #2;
    for (int i = 0; i < N_CH; i++) led_exp[i] = ((n - m_last[i]) < LHC);
    chk("seq_state",       bus.seq_state, m_ph);
    chk("core_reset",      bus.core_reset, (m_ph != 2));
    chk("core_reset_n",    bus.core_reset_n, (m_ph == 2));
    chk("lock_lost_count", bus.lock_lost_count, m_llc);
    chk("led_out",         bus.led_out, led_exp);
    chk("heartbeat",       bus.heartbeat, (m_ph == 2) ? (((n - m_run0) / HBD) % 2) : 0);
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_st(input logic [1:0] s);
    bit hit = 0;
    for (int k = 0; k < 100; k++) begin
      if (bus.seq_state == s) begin hit = 1; break; end
      @(negedge clk);
    end
    if (!hit) begin
      checks++;
      $display("FAIL wait_state: seq_state=%0d, required %0d within 100 cycles", bus.seq_state, s);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_core_reset"},   bus.core_reset, 1);
    chk({tag, "_core_reset_n"}, bus.core_reset_n, 0);
    chk({tag, "_seq_state"},    bus.seq_state, 0);
    chk({tag, "_led_out"},      bus.led_out, 0);
    chk({tag, "_heartbeat"},    bus.heartbeat, 0);
    chk({tag, "_llc"},          bus.lock_lost_count, 0);
  endtask

  initial begin
    int rel, cnt;
    bit saw0;
    logic [11:0] hbv;
    reset = 1'b1;
    bus.pll_locked = 1'b0;
    bus.status_in  = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Clean lock: 2 sync + 1 + 8 stable cycles to release.
    bus.pll_locked = 1'b1;
    rel = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (!bus.core_reset) begin rel = k; break; end
    end
    chk("release_latency", rel, 11);
    chk("run_state", bus.seq_state, 2);

    // Heartbeat over the first 12 RUN cycles: toggles every 3.
    hbv = '0;
    for (int k = 0; k < 12; k++) begin
      hbv[k] = bus.heartbeat;
      if (k < 11) @(negedge clk);
    end
    chk("hb_pattern", hbv, 12'b111000111000);

    // Lock loss from RUN.
    bus.pll_locked = 1'b0;
    wait_st(2'd3);
    chk("lost_heartbeat", bus.heartbeat, 0);
    chk("lost_core_reset", bus.core_reset, 1);
    chk("lost_count1", bus.lock_lost_count, 1);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.seq_state != 2'd3) break;
      cnt++;
      @(negedge clk);
    end
    chk("lost_hold_cycles", cnt, 4);
    chk("lost_to_wait", bus.seq_state, 0);

    // status_in[1] high before release must not light led_out[1].
    bus.status_in[1] = 1'b1;
    bus.pll_locked = 1'b1;
    wait_st(2'd2);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin @(negedge clk); cnt += bus.led_out[1]; end
    chk("held_level_no_led", cnt, 0);

    // Single pulse -> 5 cycles on.
    bus.status_in[0] = 1'b1;
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      cnt += bus.led_out[0];
      if (k == 0) bus.status_in[0] = 1'b0;
    end
    chk("led_single", cnt, 5);

    // Second pulse 3 cycles later reloads -> 8 cycles on.
    bus.status_in[0] = 1'b1;
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      cnt += bus.led_out[0];
      if (k == 0 || k == 3) bus.status_in[0] = 1'b0;
      if (k == 2) bus.status_in[0] = 1'b1;
    end
    chk("led_retrigger", cnt, 8);

    // One-cycle glitch about 5 cycles into STABLE restarts the full count.
    bus.pll_locked = 1'b0;
    wait_st(2'd0);
    bus.pll_locked = 1'b1;
    wait_st(2'd1);
    repeat (2) @(negedge clk);
    bus.pll_locked = 1'b0;
    @(negedge clk);
    bus.pll_locked = 1'b1;
    saw0 = 0;
    rel = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.seq_state == 2'd0) saw0 = 1;
      if (!bus.core_reset) begin rel = k; break; end
    end
    chk("glitch_back_to_wait", saw0, 1);
    chk("glitch_full_restart", rel, 11);
    chk("lost_count2", bus.lock_lost_count, 2);

    // Saturation of lock_lost_count.
    for (int r = 0; r < 300; r++) begin
      bus.pll_locked = 1'b0;
      wait_st(2'd0);
      bus.pll_locked = 1'b1;
      wait_st(2'd2);
    end
    chk("lost_count_sat", bus.lock_lost_count, 255);

    // Reset asserted mid-STABLE.
    bus.pll_locked = 1'b0;
    wait_st(2'd0);
    bus.pll_locked = 1'b1;
    wait_st(2'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset_vals("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
